// File: rtl/sap_controller_sequencer_if.sv
// ----------------------------------------------------------------------------
// sap_controller_sequencer_if
//   Bundle between the SAP-1 control sequencer and the datapath it drives.
//   Carries the run/instruction inputs and the full control word plus status.
//
//   modport master : datapath / environment side (drives run and instruction,
//                    observes the control word, t_state and halted)
//   modport slave  : the sequencer itself (consumes run and instruction,
//                    produces the control word, t_state and halted)
// ----------------------------------------------------------------------------
interface sap_controller_sequencer_if;
   logic       run;
   logic [3:0] instruction;
   logic       pc_inc;
   logic       pc_to_bus;
   logic       load_mar;
   logic       ram_to_bus;
   logic       load_ir;
   logic       ir_to_bus;
   logic       load_a;
   logic       a_to_bus;
   logic       alu_sub;
   logic       alu_to_bus;
   logic       load_b;
   logic       load_out;
   logic [5:0] t_state;
   logic       halted;

   modport master (
      output run, instruction,
      input  pc_inc, pc_to_bus, load_mar, ram_to_bus, load_ir, ir_to_bus,
      input  load_a, a_to_bus, alu_sub, alu_to_bus, load_b, load_out,
      input  t_state, halted
   );

   modport slave (
      input  run, instruction,
      output pc_inc, pc_to_bus, load_mar, ram_to_bus, load_ir, ir_to_bus,
      output load_a, a_to_bus, alu_sub, alu_to_bus, load_b, load_out,
      output t_state, halted
   );
endinterface

// File: rtl/sap_controller_sequencer.sv
// ----------------------------------------------------------------------------
// sap_controller_sequencer
//   SAP-1 control unit. Steps a six-state ring (T1-T3 fetch, T4-T6 execute)
//   and decodes the opcode into the control word for PC, MAR, RAM, IR, A,
//   ALU, B and OUT. HLT parks the sequencer in a sticky HALT state that only
//   reset_n leaves.
//
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset, returns to IDLE
//   bus      : slave side of sap_controller_sequencer_if
//                run, instruction            -> in
//                control word, t_state, halted <- out
// ----------------------------------------------------------------------------
module sap_controller_sequencer (
   input  logic                             clock,
   input  logic                             reset_n,
   sap_controller_sequencer_if.slave        bus
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Bit positions inside the packed control word.
   localparam int C_CP = 11;
   localparam int C_EP = 10;
   localparam int C_LM = 9;
   localparam int C_CE = 8;
   localparam int C_LI = 7;
   localparam int C_EI = 6;
   localparam int C_LA = 5;
   localparam int C_EA = 4;
   localparam int C_SU = 3;
   localparam int C_EU = 2;
   localparam int C_LB = 1;
   localparam int C_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   state_t      state_q;
   logic [3:0]  opcode_q;
   logic [11:0] ctrl_s;
   logic [5:0]  t_state_s;

   // Ring sequencing; opcode is captured on the edge leaving T4 so that
   // T5/T6 no longer depend on the IR contents.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         opcode_q <= 4'b0000;
      end else begin
         case (state_q)
            S_IDLE: if (bus.run) state_q <= S_T1;
            S_T1:   if (bus.run) state_q <= S_T2;
            S_T2:   if (bus.run) state_q <= S_T3;
            S_T3:   if (bus.run) state_q <= S_T4;
            S_T4: begin
               if (bus.run) begin
                  opcode_q <= bus.instruction;
                  state_q  <= (bus.instruction == OP_HLT) ? S_HALT : S_T5;
               end
            end
            S_T5:   if (bus.run) state_q <= S_T6;
            S_T6:   if (bus.run) state_q <= S_T1;
            S_HALT: state_q <= S_HALT;   // run is ignored here
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Control-word decode. run=0 blanks everything so a frozen state never
   // repeats a load or increment; T4 uses the live opcode, T5/T6 the latch.
   always_comb begin
      ctrl_s = 12'h000;
      if (bus.run) begin
         case (state_q)
            S_T1: begin
               ctrl_s[C_EP] = 1'b1;
               ctrl_s[C_LM] = 1'b1;
            end
            S_T2: ctrl_s[C_CP] = 1'b1;
            S_T3: begin
               ctrl_s[C_CE] = 1'b1;
               ctrl_s[C_LI] = 1'b1;
            end
            S_T4: begin
               case (bus.instruction)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     ctrl_s[C_EI] = 1'b1;
                     ctrl_s[C_LM] = 1'b1;
                  end
                  OP_OUT: begin
                     ctrl_s[C_EA] = 1'b1;
                     ctrl_s[C_LO] = 1'b1;
                  end
                  default: ctrl_s = 12'h000;
               endcase
            end
            S_T5: begin
               case (opcode_q)
                  OP_LDA: begin
                     ctrl_s[C_CE] = 1'b1;
                     ctrl_s[C_LA] = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ctrl_s[C_CE] = 1'b1;
                     ctrl_s[C_LB] = 1'b1;
                  end
                  default: ctrl_s = 12'h000;
               endcase
            end
            S_T6: begin
               case (opcode_q)
                  OP_ADD: begin
                     ctrl_s[C_EU] = 1'b1;
                     ctrl_s[C_LA] = 1'b1;
                  end
                  OP_SUB: begin
                     ctrl_s[C_SU] = 1'b1;
                     ctrl_s[C_EU] = 1'b1;
                     ctrl_s[C_LA] = 1'b1;
                  end
                  default: ctrl_s = 12'h000;
               endcase
            end
            default: ctrl_s = 12'h000;
         endcase
      end else begin
         ctrl_s = 12'h000;
      end
   end

   // One-hot T-state view; stays visible while run=0 freezes the ring.
   always_comb begin
      t_state_s = 6'b000000;
      case (state_q)
         S_T1:    t_state_s = 6'b000001;
         S_T2:    t_state_s = 6'b000010;
         S_T3:    t_state_s = 6'b000100;
         S_T4:    t_state_s = 6'b001000;
         S_T5:    t_state_s = 6'b010000;
         S_T6:    t_state_s = 6'b100000;
         default: t_state_s = 6'b000000;
      endcase
   end

   assign bus.pc_inc     = ctrl_s[C_CP];
   assign bus.pc_to_bus  = ctrl_s[C_EP];
   assign bus.load_mar   = ctrl_s[C_LM];
   assign bus.ram_to_bus = ctrl_s[C_CE];
   assign bus.load_ir    = ctrl_s[C_LI];
   assign bus.ir_to_bus  = ctrl_s[C_EI];
   assign bus.load_a     = ctrl_s[C_LA];
   assign bus.a_to_bus   = ctrl_s[C_EA];
   assign bus.alu_sub    = ctrl_s[C_SU];
   assign bus.alu_to_bus = ctrl_s[C_EU];
   assign bus.load_b     = ctrl_s[C_LB];
   assign bus.load_out   = ctrl_s[C_LO];
   assign bus.t_state    = t_state_s;
   assign bus.halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sap_controller_sequencer
//   Self-checking bench: table-driven LDA walk, hand-written corner sequences
//   (reset mid-fetch, opcode change after T4, HLT, run freeze, undefined op)
//   and randomized run/instruction/reset against a phase-counter model.
// ----------------------------------------------------------------------------
module tb_sap_controller_sequencer;

   localparam logic [11:0] CP = 12'h800;
   localparam logic [11:0] EP = 12'h400;
   localparam logic [11:0] LM = 12'h200;
   localparam logic [11:0] CE = 12'h100;
   localparam logic [11:0] LI = 12'h080;
   localparam logic [11:0] EI = 12'h040;
   localparam logic [11:0] LA = 12'h020;
   localparam logic [11:0] EA = 12'h010;
   localparam logic [11:0] SU = 12'h008;
   localparam logic [11:0] EU = 12'h004;
   localparam logic [11:0] LB = 12'h002;
   localparam logic [11:0] LO = 12'h001;

   localparam logic [3:0] LDA = 4'b0000;
   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SUB = 4'b0010;
   localparam logic [3:0] OUT = 4'b1110;
   localparam logic [3:0] HLT = 4'b1111;

   logic clock;
   logic reset_n;
   sap_controller_sequencer_if bus ();

   sap_controller_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [11:0] act_c;
   assign act_c = {bus.pc_inc, bus.pc_to_bus, bus.load_mar, bus.ram_to_bus,
                   bus.load_ir, bus.ir_to_bus, bus.load_a, bus.a_to_bus,
                   bus.alu_sub, bus.alu_to_bus, bus.load_b, bus.load_out};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: phase 0 = idle, 1..6 = T1..T6, -1 = halted; op_m = latched opcode.
   int         phase_m = 0;
   logic [3:0] op_m    = 4'b0000;

   function automatic logic [11:0] model_ctrl(input int ph, input logic [3:0] op_l,
                                              input logic run, input logic [3:0] ins);
      logic [11:0] c;
      c = 12'h000;
      if (run) begin
         if (ph == 1) c = EP | LM;
         else if (ph == 2) c = CP;
         else if (ph == 3) c = CE | LI;
         else if (ph == 4) begin
            if (ins == LDA || ins == ADD || ins == SUB) c = EI | LM;
            else if (ins == OUT) c = EA | LO;
         end else if (ph == 5) begin
            if (op_l == LDA) c = CE | LA;
            else if (op_l == ADD || op_l == SUB) c = CE | LB;
         end else if (ph == 6) begin
            if (op_l == ADD) c = EU | LA;
            else if (op_l == SUB) c = SU | EU | LA;
         end
      end
      return c;
   endfunction

   function automatic logic [5:0] model_t(input int ph);
      logic [5:0] t;
      t = 6'b000000;
      if (ph >= 1 && ph <= 6) t = 6'b000001 << (ph - 1);
      return t;
   endfunction

   task automatic compare(input string name, input logic [5:0] et,
                          input logic eh, input logic [11:0] ec);
      n_cmp++;
      if (bus.t_state !== et || bus.halted !== eh || act_c !== ec) begin
         n_bad++;
         $display("FAIL %s @%0t: got t=%b h=%b c=%b, want t=%b h=%b c=%b",
                  name, $time, bus.t_state, bus.halted, act_c, et, eh, ec);
      end
   endtask

   task automatic check_model(input string name);
      int nb;
      compare(name, model_t(phase_m), (phase_m == -1),
              model_ctrl(phase_m, op_m, bus.run, bus.instruction));
      nb = int'(bus.pc_to_bus) + int'(bus.ram_to_bus) + int'(bus.ir_to_bus)
         + int'(bus.a_to_bus) + int'(bus.alu_to_bus);
      n_cmp++;
      if (nb > 1) begin
         n_bad++;
         $display("FAIL bus_excl @%0t: %0d drivers on W bus, want <=1", $time, nb);
      end
   endtask

   task automatic model_advance();
      if (phase_m == -1) phase_m = -1;
      else if (!bus.run) phase_m = phase_m;
      else if (phase_m == 4) begin
         op_m    = bus.instruction;
         phase_m = (bus.instruction == HLT) ? -1 : 5;
      end else if (phase_m == 6) phase_m = 1;
      else phase_m = phase_m + 1;
   endtask

   task automatic settle(input string name);
      @(negedge clock);
      check_model(name);
   endtask

   task automatic edge_adv();
      @(posedge clock);
      model_advance();
      #1;
   endtask

   task automatic tick(input string name);
      settle(name);
      edge_adv();
   endtask

   // One clock with a hand-written expectation plus the model check.
   task automatic cyc(input string name, input logic [5:0] et,
                      input logic [11:0] ec, input logic eh);
      settle(name);
      compare(name, et, eh, ec);
      edge_adv();
   endtask

   task automatic apply(input logic r, input logic [3:0] ins);
      bus.run         = r;
      bus.instruction = ins;
   endtask

   task automatic do_reset();
      bus.run = 1'b0;
      reset_n = 1'b0;
      phase_m = 0;
      #1;
      compare("reset_async", 6'b000000, 1'b0, 12'h000);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic       run;
      logic [3:0] ins;
      logic [5:0] t;
      logic [11:0] c;
   } vec_t;

   vec_t vecs[8];

   logic [3:0] pool[8];

   initial begin
      vecs[0] = '{1'b1, LDA, 6'b000000, 12'h000};
      vecs[1] = '{1'b1, LDA, 6'b000001, EP | LM};
      vecs[2] = '{1'b1, LDA, 6'b000010, CP};
      vecs[3] = '{1'b1, LDA, 6'b000100, CE | LI};
      vecs[4] = '{1'b1, LDA, 6'b001000, EI | LM};
      vecs[5] = '{1'b1, LDA, 6'b010000, CE | LA};
      vecs[6] = '{1'b1, LDA, 6'b100000, 12'h000};
      vecs[7] = '{1'b1, LDA, 6'b000001, EP | LM};

      pool[0] = LDA; pool[1] = ADD; pool[2] = SUB; pool[3] = OUT;
      pool[4] = HLT; pool[5] = 4'b0111; pool[6] = 4'b0011; pool[7] = 4'b1001;

      reset_n = 1'b0;
      apply(1'b0, LDA);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Reset asserted while in T3, then idle with run=0.
      apply(1'b1, LDA);
      cyc("t1_idle", 6'b000000, 12'h000, 1'b0);
      cyc("t1_T1", 6'b000001, EP | LM, 1'b0);
      cyc("t1_T2", 6'b000010, CP, 1'b0);
      settle("t1_T3");
      compare("t1_T3", 6'b000100, 1'b0, CE | LI);
      reset_n = 1'b0;
      phase_m = 0;
      #1;
      compare("t1_rst_mid", 6'b000000, 1'b0, 12'h000);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      bus.run = 1'b0;
      for (int i = 0; i < 5; i++) cyc("t1_idle_run0", 6'b000000, 12'h000, 1'b0);

      // LDA walk from the table.
      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].run, vecs[i].ins);
         cyc($sformatf("t2_vec%0d", i), vecs[i].t, vecs[i].c, 1'b0);
      end

      // SUB latched at T4 exit; opcode changes to ADD during T5.
      do_reset();
      apply(1'b1, SUB);
      cyc("t3_idle", 6'b000000, 12'h000, 1'b0);
      cyc("t3_T1", 6'b000001, EP | LM, 1'b0);
      cyc("t3_T2", 6'b000010, CP, 1'b0);
      cyc("t3_T3", 6'b000100, CE | LI, 1'b0);
      cyc("t3_T4", 6'b001000, EI | LM, 1'b0);
      apply(1'b1, ADD);
      cyc("t3_T5", 6'b010000, CE | LB, 1'b0);
      cyc("t3_T6", 6'b100000, SU | EU | LA, 1'b0);
      cyc("t3_T1b", 6'b000001, EP | LM, 1'b0);

      // HLT is sticky through run toggling; only reset clears it.
      do_reset();
      apply(1'b1, HLT);
      cyc("t4_idle", 6'b000000, 12'h000, 1'b0);
      cyc("t4_T1", 6'b000001, EP | LM, 1'b0);
      cyc("t4_T2", 6'b000010, CP, 1'b0);
      cyc("t4_T3", 6'b000100, CE | LI, 1'b0);
      cyc("t4_T4", 6'b001000, 12'h000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         bus.run = (i % 2 == 0) ? 1'b0 : 1'b1;
         cyc("t4_halt", 6'b000000, 12'h000, 1'b1);
      end
      do_reset();
      cyc("t4_cleared", 6'b000000, 12'h000, 1'b0);

      // Freeze in T2, then resume for exactly one pc_inc.
      do_reset();
      apply(1'b1, LDA);
      cyc("t5_idle", 6'b000000, 12'h000, 1'b0);
      cyc("t5_T1", 6'b000001, EP | LM, 1'b0);
      bus.run = 1'b0;
      for (int i = 0; i < 3; i++) cyc("t5_hold", 6'b000010, 12'h000, 1'b0);
      bus.run = 1'b1;
      cyc("t5_resume", 6'b000010, CP, 1'b0);
      cyc("t5_T3", 6'b000100, CE | LI, 1'b0);

      // Undefined opcode runs as NOP.
      do_reset();
      apply(1'b1, 4'b0111);
      cyc("t6_idle", 6'b000000, 12'h000, 1'b0);
      cyc("t6_T1", 6'b000001, EP | LM, 1'b0);
      cyc("t6_T2", 6'b000010, CP, 1'b0);
      cyc("t6_T3", 6'b000100, CE | LI, 1'b0);
      cyc("t6_T4", 6'b001000, 12'h000, 1'b0);
      cyc("t6_T5", 6'b010000, 12'h000, 1'b0);
      cyc("t6_T6", 6'b100000, 12'h000, 1'b0);
      cyc("t6_T1b", 6'b000001, EP | LM, 1'b0);

      // OUT instruction at T4.
      do_reset();
      apply(1'b1, OUT);
      for (int i = 0; i < 4; i++) tick("t7_fetch");
      cyc("t7_T4_out", 6'b001000, EA | LO, 1'b0);
      cyc("t7_T5_out", 6'b010000, 12'h000, 1'b0);

      // Random run/instruction/reset against the model.
      do_reset();
      for (int n = 0; n < 800; n++) begin
         int idx;
         idx = $urandom_range(0, 7);
         if (idx == 4 && $urandom_range(0, 3) != 0) idx = 1;
         apply(($urandom_range(0, 3) != 0), pool[idx]);
         if ($urandom_range(0, 39) == 0) do_reset();
         else tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
